// File: rtl/phasemeter_ctrl.sv
// Phasemeter control: NCO retune sequencing aligned to CIC decimation,
// post-retune sample flush and a 2-entry output sample buffer.
module phasemeter_ctrl #(
    parameter int FREQ_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [FREQ_WIDTH-1:0] DEFAULT_FREQ = 32'd343597384,
    parameter int FLUSH_SAMPLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [FREQ_WIDTH-1:0] s_axis_freq_tdata,
    input  logic                  s_axis_freq_tvalid,
    output logic                  s_axis_freq_tready,
    input  logic                  d_clk,
    input  logic [DATA_WIDTH-1:0] cic_data,
    output logic [FREQ_WIDTH-1:0] FREQ_WORD,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [15:0]           drop_count,
    output logic [1:0]            state
);

    localparam int FCW = (FLUSH_SAMPLES > 1) ? $clog2(FLUSH_SAMPLES) : 1;
    localparam logic [FCW-1:0] FLUSH_LAST =
        FCW'((FLUSH_SAMPLES > 0) ? FLUSH_SAMPLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PEND  = 2'd2,
        FLUSH = 2'd3
    } state_e;

    state_e                 state_q;
    logic [FREQ_WIDTH-1:0]  freq_q;
    logic [FREQ_WIDTH-1:0]  pend_q;
    logic [FCW-1:0]         flush_q;

    logic [DATA_WIDTH-1:0]  head_q, head_d;
    logic [DATA_WIDTH-1:0]  tail_q, tail_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [15:0]            drop_q, drop_d;

    logic accept;
    logic push;
    logic pop;

    assign s_axis_freq_tready = (state_q == RUN) && enable;
    assign accept = s_axis_freq_tvalid && s_axis_freq_tready;
    assign push   = enable && d_clk && ((state_q == RUN) || (state_q == PEND));
    assign pop    = m_axis_tvalid && m_axis_tready;

    assign FREQ_WORD     = freq_q;
    assign m_axis_tdata  = head_q;
    assign m_axis_tvalid = (cnt_q != 2'd0);
    assign drop_count    = drop_q;
    assign state         = state_q;

    // The new word takes effect only on a decimation boundary so the
    // CIC never integrates a sample straddling two frequencies.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            freq_q  <= DEFAULT_FREQ;
            pend_q  <= DEFAULT_FREQ;
            flush_q <= '0;
        end else if (!enable) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: state_q <= RUN;
                RUN: begin
                    if (accept) begin
                        pend_q  <= s_axis_freq_tdata;
                        state_q <= PEND;
                    end
                end
                PEND: begin
                    if (d_clk) begin
                        freq_q  <= pend_q;
                        flush_q <= '0;
                        state_q <= (FLUSH_SAMPLES == 0) ? RUN : FLUSH;
                    end
                end
                FLUSH: begin
                    if (d_clk) begin
                        flush_q <= flush_q + FCW'(1);
                        if (flush_q == FLUSH_LAST) state_q <= RUN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Head register feeds m_axis_tdata directly so it holds under back-pressure.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        drop_d = drop_q;
        if (!enable) begin
            cnt_d = 2'd0;
        end else begin
            case (cnt_q)
                2'd0: begin
                    if (push) begin
                        head_d = cic_data;
                        cnt_d  = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_d = cic_data;
                    end else if (push) begin
                        tail_d = cic_data;
                        cnt_d  = 2'd2;
                    end else if (pop) begin
                        cnt_d = 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_d = tail_q;
                        if (push) tail_d = cic_data;
                        else      cnt_d  = 2'd1;
                    end else if (push && (drop_q != 16'hFFFF)) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
            drop_q <= 16'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
        end
    end

endmodule

// File: tb/tb_phasemeter_ctrl.sv
// Self-checking bench for phasemeter_ctrl against a queue-based
// behavioural model of the retune / flush / buffer rules.
module tb_phasemeter_ctrl;

    localparam int FLUSH_SAMPLES = 2;
    localparam logic [31:0] DEF_FREQ = 32'd343597384;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] s_axis_freq_tdata = '0;
    logic        s_axis_freq_tvalid = 1'b0;
    logic        s_axis_freq_tready;
    logic        d_clk = 1'b0;
    logic [31:0] cic_data = '0;
    logic [31:0] FREQ_WORD;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [15:0] drop_count;
    logic [1:0]  state;

    int tests = 0;
    int fails = 0;
    logic [31:0] cnt = 0;

    // Behavioural model: mode 0..3, sample buffer as a bounded queue.
    int          m_mode;
    int          m_fl;
    int          m_drop;
    logic [31:0] m_freq;
    logic [31:0] m_pend;
    logic [31:0] q[$];

    phasemeter_ctrl #(
        .FREQ_WIDTH(32),
        .DATA_WIDTH(32),
        .DEFAULT_FREQ(DEF_FREQ),
        .FLUSH_SAMPLES(FLUSH_SAMPLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .s_axis_freq_tdata(s_axis_freq_tdata),
        .s_axis_freq_tvalid(s_axis_freq_tvalid),
        .s_axis_freq_tready(s_axis_freq_tready),
        .d_clk(d_clk),
        .cic_data(cic_data),
        .FREQ_WORD(FREQ_WORD),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .drop_count(drop_count),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = 0;
        m_fl   = 0;
        m_drop = 0;
        m_freq = DEF_FREQ;
        m_pend = DEF_FREQ;
        q.delete();
    endtask

    task automatic model_step();
        bit pop;
        bit push;
        pop  = (q.size() > 0) && m_axis_tready;
        push = 1'b0;
        if (!enable) begin
            m_mode = 0;
            q.delete();
            return;
        end
        case (m_mode)
            0: m_mode = 1;
            1: begin
                push = d_clk;
                if (s_axis_freq_tvalid) begin
                    m_pend = s_axis_freq_tdata;
                    m_mode = 2;
                end
            end
            2: begin
                push = d_clk;
                if (d_clk) begin
                    m_freq = m_pend;
                    m_fl   = 0;
                    m_mode = (FLUSH_SAMPLES == 0) ? 1 : 3;
                end
            end
            default: begin
                if (d_clk) begin
                    m_fl++;
                    if (m_fl == FLUSH_SAMPLES) m_mode = 1;
                end
            end
        endcase
        if (pop) void'(q.pop_front());
        if (push) begin
            if (q.size() < 2) q.push_back(cic_data);
            else if (m_drop < 65535) m_drop++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        #1;
    endtask

    function automatic logic [83:0] obs();
        return {state, m_axis_tvalid, s_axis_freq_tready, drop_count,
                FREQ_WORD, m_axis_tvalid ? m_axis_tdata : 32'd0};
    endfunction

    function automatic logic [83:0] expv();
        logic [1:0]  st;
        logic [15:0] dr;
        st = m_mode[1:0];
        dr = m_drop[15:0];
        return {st, q.size() > 0, (m_mode == 1) && enable, dr,
                m_freq, (q.size() > 0) ? q[0] : 32'd0};
    endfunction

    task automatic test_reset();
        model_reset();
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (obs() !== expv()) begin
                fails++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
        tests++;
        if (FREQ_WORD !== DEF_FREQ || state !== 2'd0 || s_axis_freq_tready !== 1'b0) begin
            fails++;
            $display("FAIL reset_vals freq=%0d st=%0d rdy=%0b exp freq=%0d st=0 rdy=0",
                     FREQ_WORD, state, s_axis_freq_tready, DEF_FREQ);
        end
        #3 rst = 1'b1;
        #1;
        tests++;
        if (state !== 2'd0) begin
            fails++;
            $display("FAIL reset_release st=%0d exp=0", state);
        end
        tick();
        tests++;
        if (obs() !== expv() || state !== 2'd1) begin
            fails++;
            $display("FAIL reset_first_edge got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_next;
        int emitted;
        exp_next = cnt;
        emitted = 0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 128; i++) begin
            d_clk = (i % 16 == 3);
            cic_data = d_clk ? cnt : $urandom;
            tick();
            if (d_clk) cnt++;
            tests++;
            if (obs() !== expv()) begin
                fails++;
                $display("FAIL stream cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
            if (d_clk) begin
                tests++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_next) begin
                    fails++;
                    $display("FAIL stream_order v=%0b d=%0d exp v=1 d=%0d",
                             m_axis_tvalid, m_axis_tdata, exp_next);
                end
                exp_next++;
                emitted++;
            end
        end
        d_clk = 1'b0;
        tests++;
        if (emitted != 8 || drop_count !== 16'd0) begin
            fails++;
            $display("FAIL stream_count n=%0d drop=%0d exp n=8 drop=0", emitted, drop_count);
        end
    endtask

    task automatic test_retune();
        int seq[$];
        int chg;
        logic [31:0] old_f;
        chg = -1;
        old_f = FREQ_WORD;
        tests++;
        if (s_axis_freq_tready !== 1'b1) begin
            fails++;
            $display("FAIL retune_ready got=%0b exp=1", s_axis_freq_tready);
        end
        seq.push_back(int'(state));
        s_axis_freq_tvalid = 1'b1;
        s_axis_freq_tdata = 32'd340161409;
        tick();
        s_axis_freq_tvalid = 1'b0;
        if (int'(state) != seq[$]) seq.push_back(int'(state));
        for (int i = 0; i < 80; i++) begin
            d_clk = (i % 16 == 3);
            cic_data = d_clk ? cnt : $urandom;
            tick();
            if (d_clk) cnt++;
            if (int'(state) != seq[$]) seq.push_back(int'(state));
            if (chg < 0 && FREQ_WORD !== old_f) chg = i;
            tests++;
            if (obs() !== expv()) begin
                fails++;
                $display("FAIL retune cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
        d_clk = 1'b0;
        tests++;
        if (seq.size() != 4 || seq[0] != 1 || seq[1] != 2 || seq[2] != 3 || seq[3] != 1) begin
            fails++;
            $display("FAIL retune_seq got=%p exp='{1,2,3,1}", seq);
        end
        tests++;
        if (chg != 3 || FREQ_WORD !== 32'd340161409) begin
            fails++;
            $display("FAIL retune_timing chg=%0d freq=%0d exp chg=3 freq=340161409", chg, FREQ_WORD);
        end
    endtask

    task automatic test_backpressure();
        int base;
        logic [31:0] v0;
        base = m_drop;
        v0 = cnt;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            d_clk = (i % 4 == 1);
            cic_data = d_clk ? cnt : $urandom;
            tick();
            if (d_clk) cnt++;
            tests++;
            if (obs() !== expv()) begin
                fails++;
                $display("FAIL backpressure cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
            if (i >= 1 && m_axis_tdata !== v0) begin
                fails++;
                $display("FAIL bp_stable cyc=%0d got=%0d exp=%0d", i, m_axis_tdata, v0);
            end
        end
        d_clk = 1'b0;
        tests++;
        if (int'(drop_count) != base + 3) begin
            fails++;
            $display("FAIL bp_drops got=%0d exp=%0d", drop_count, base + 3);
        end
        m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ((i < 2) ? (m_axis_tvalid !== 1'b1 || m_axis_tdata !== v0 + i)
                        : (m_axis_tvalid !== 1'b0)) begin
                fails++;
                $display("FAIL bp_drain step=%0d v=%0b d=%0d exp d=%0d", i,
                         m_axis_tvalid, m_axis_tdata, v0 + i);
            end
            tick();
        end
    endtask

    task automatic test_full_pop();
        logic [31:0] b;
        int base;
        base = m_drop;
        m_axis_tready = 1'b0;
        d_clk = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cic_data = cnt;
            tick();
            cnt++;
        end
        b = cnt - 1;
        m_axis_tready = 1'b1;
        cic_data = cnt;
        tick();
        cnt++;
        d_clk = 1'b0;
        tests++;
        if (obs() !== expv() || int'(drop_count) != base || m_axis_tdata !== b) begin
            fails++;
            $display("FAIL full_pop got=%h exp=%h head=%0d exp head=%0d",
                     obs(), expv(), m_axis_tdata, b);
        end
        tick();
        tests++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== b + 1) begin
            fails++;
            $display("FAIL full_pop_order v=%0b d=%0d exp d=%0d", m_axis_tvalid, m_axis_tdata, b + 1);
        end
        tick();
        tests++;
        if (obs() !== expv() || m_axis_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL full_pop_empty got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            enable = ($urandom % 25) != 0;
            s_axis_freq_tvalid = ($urandom % 8) == 0;
            s_axis_freq_tdata = $urandom;
            d_clk = ($urandom % 4) == 0;
            cic_data = $urandom;
            m_axis_tready = ($urandom % 10) < 6;
            tick();
            tests++;
            if (obs() !== expv()) begin
                fails++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
        s_axis_freq_tvalid = 1'b0;
        d_clk = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_reset_flush();
        int n;
        m_axis_tready = 1'b1;
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        s_axis_freq_tvalid = 1'b1;
        s_axis_freq_tdata = 32'd123456789;
        tick();
        s_axis_freq_tvalid = 1'b0;
        n = 0;
        while (m_mode != 3 && n < 100) begin
            d_clk = (n % 4 == 1);
            cic_data = $urandom;
            tick();
            n++;
        end
        d_clk = 1'b0;
        tests++;
        if (m_mode != 3 || state !== 2'd3) begin
            fails++;
            $display("FAIL rf_reach_flush st=%0d exp=3 after %0d cycles", state, n);
        end
        #3 rst = 1'b0;
        #1;
        model_reset();
        tests++;
        if (state !== 2'd0 || FREQ_WORD !== DEF_FREQ || m_axis_tvalid !== 1'b0 ||
            drop_count !== 16'd0 || s_axis_freq_tready !== 1'b0) begin
            fails++;
            $display("FAIL rf_async st=%0d freq=%0d v=%0b drop=%0d exp 0 %0d 0 0",
                     state, FREQ_WORD, m_axis_tvalid, drop_count, DEF_FREQ);
        end
        rst = 1'b1;
        tick();
        tests++;
        if (obs() !== expv()) begin
            fails++;
            $display("FAIL rf_restart got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_saturate();
        int n;
        rst = 1'b0;
        #2;
        model_reset();
        rst = 1'b1;
        enable = 1'b1;
        m_axis_tready = 1'b0;
        d_clk = 1'b1;
        n = 0;
        while (m_drop < 65534 && n < 70000) begin
            cic_data = $urandom;
            tick();
            n++;
        end
        tests++;
        if (drop_count !== 16'hFFFE) begin
            fails++;
            $display("FAIL sat_fffe got=%h exp=fffe after %0d cycles", drop_count, n);
        end
        for (int i = 0; i < 3; i++) begin
            cic_data = $urandom;
            tick();
        end
        d_clk = 1'b0;
        tests++;
        if (drop_count !== 16'hFFFF || obs() !== expv()) begin
            fails++;
            $display("FAIL sat_hold got=%h exp=ffff vec=%h exp=%h", drop_count, obs(), expv());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_retune();
        test_backpressure();
        test_full_pop();
        test_random();
        test_reset_flush();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/phasemeter_ctrl.md
PHASEMETER_CTRL -- requirements
Module: phasemeter_ctrl

Interface
REQ-001 SHALL have parameter FREQ_WIDTH, default 32, NCO frequency-word width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, CIC output sample width.
REQ-003 SHALL have parameter DEFAULT_FREQ, default 32'd343597384, frequency word applied after reset.
REQ-004 SHALL have parameter FLUSH_SAMPLES, default 2, decimated samples discarded after a retune (CIC order N).
REQ-005 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port enable  input  1  run request; low forces IDLE.
REQ-008 SHALL have port s_axis_freq_tdata  input  FREQ_WIDTH  requested frequency word.
REQ-009 SHALL have ports s_axis_freq_tvalid input 1 and s_axis_freq_tready output 1, retune handshake.
REQ-010 SHALL have port d_clk  input  1  one-cycle strobe from CIC marking a valid decimated sample.
REQ-011 SHALL have port cic_data  input  DATA_WIDTH  CIC output, valid when d_clk=1.
REQ-012 SHALL have port FREQ_WORD  output  FREQ_WIDTH  registered word driving the NCO.
REQ-013 SHALL have ports m_axis_tdata output DATA_WIDTH, m_axis_tvalid output 1, m_axis_tready input 1, sample stream.
REQ-014 SHALL have port drop_count  output  16  saturating count of samples lost to a full buffer.
REQ-015 SHALL have port state  output  2  current FSM state encoding (IDLE=0, RUN=1, PEND=2, FLUSH=3).

Function
REQ-016 FSM SHALL have states IDLE, RUN, PEND, FLUSH; enable=0 in any state SHALL go to IDLE next cycle.
REQ-017 IDLE->RUN SHALL occur on the first cycle enable=1; FREQ_WORD unchanged.
REQ-018 s_axis_freq_tready SHALL be 1 only in RUN with enable=1; a transfer (tvalid&tready) SHALL latch tdata into a pending register and move to PEND.
REQ-019 In PEND, FREQ_WORD SHALL load the pending word on the cycle after the first d_clk strobe (update aligned to decimation boundary), then enter FLUSH with flush counter=0; the PEND-exit d_clk sample SHALL be pushed to the buffer.
REQ-020 In FLUSH, each d_clk SHALL increment the flush counter and its sample SHALL be discarded (not pushed, not counted as dropped); after FLUSH_SAMPLES strobes go to RUN.
REQ-021 FLUSH_SAMPLES=0 SHALL go PEND->RUN directly.
REQ-022 In RUN and PEND, each d_clk SHALL push cic_data into a 2-entry FIFO; in IDLE and FLUSH samples SHALL be discarded.
REQ-023 m_axis_tvalid SHALL equal FIFO non-empty; m_axis_tdata SHALL be the head entry, registered, stable while tvalid&!tready.
REQ-024 Push with FIFO full and no simultaneous pop SHALL drop the new sample and increment drop_count, saturating at 16'hFFFF.
REQ-025 Simultaneous push and pop on a full FIFO SHALL accept the push (no drop).
REQ-026 Push-to-tvalid latency SHALL be 1 cycle when FIFO empty.
REQ-027 Entering IDLE SHALL flush the FIFO (tvalid=0 next cycle); drop_count SHALL be retained.
REQ-028 A retune request SHALL NOT be accepted in PEND or FLUSH (tready=0); back-pressure on the config stream only.

Reset
REQ-029 On rst=0, asynchronously: state=IDLE, FREQ_WORD=DEFAULT_FREQ, FIFO empty, m_axis_tvalid=0, s_axis_freq_tready=0, drop_count=0, flush counter=0, pending word=DEFAULT_FREQ.
REQ-030 Reset asserted mid-PEND or mid-FLUSH SHALL abandon the retune; FREQ_WORD SHALL return to DEFAULT_FREQ.
REQ-031 After rst deassertion, first state change SHALL occur no earlier than the first clk rising edge.

Verification
REQ-032 Reset, enable=1, d_clk every 16 cycles, cic_data=counter, tready=1 -> FREQ_WORD=343597384, samples 0,1,2... emitted in order, 1-cycle latency, drop_count=0.
REQ-033 In RUN send tdata=340161409 -> tready drops, FREQ_WORD changes exactly one cycle after next d_clk, that sample emitted, next 2 samples absent, then stream resumes; state sequence 1,2,3,1.
REQ-034 tready=0 for 5 d_clk strobes -> exactly 2 samples held, drop_count=3, tdata stable; tready=1 drains the 2 held samples oldest first.
REQ-035 FIFO full, tready=1 coincident with d_clk -> no drop, count unchanged, order preserved.
REQ-036 rst pulsed low mid-FLUSH -> immediately IDLE, FREQ_WORD=343597384, tvalid=0, drop_count=0.
REQ-037 drop_count forced to 16'hFFFE then 3 overflow drops -> holds 16'hFFFF.
